// File: rtl/logic_unit_pkg.sv
// Shared definitions for the logic unit: opcode encodings and FSM states.
// The ALU decode stage and the pipelined logic unit both use these.
package logic_unit_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_AND    = 3'b000;
  localparam opcode_t OP_OR     = 3'b001;
  localparam opcode_t OP_XOR    = 3'b010;
  localparam opcode_t OP_NOR    = 3'b011;
  localparam opcode_t OP_NAND   = 3'b100;
  localparam opcode_t OP_XNOR   = 3'b101;
  localparam opcode_t OP_ANDN   = 3'b110;
  localparam opcode_t OP_POPCNT = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for the logic unit: operand side (in_*) and result side
// (out_*). The master drives operands and consumes results; the slave is
// the logic unit itself.
interface logic_unit_pipe_if
  import logic_unit_pkg::*;
#(
  parameter int N = 32
);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  opcode_t       opcode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out;
  logic          zero;
  logic          parity;
  logic          busy;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, out, zero, parity, busy
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, out, zero, parity, busy
  );

endinterface

// File: rtl/logic_unit_pipe_popcount_chunk.sv
// Combinational ones-count of one CHUNK-bit slice; the POPCNT loop in the
// logic unit consumes one slice per cycle through this block.
module popcount_chunk
  import logic_unit_pkg::*;
#(
  parameter int CHUNK = 8,
  localparam int CW   = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] slice_i,
  output logic [CW-1:0]    ones_o
);

  // Sum every bit of the slice into a count wide enough for all-ones.
  always_comb begin
    ones_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      ones_o = ones_o + CW'(slice_i[i]);
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered, handshaked logic unit. Logic ops finish in one cycle; POPCNT
// walks the operand CHUNK bits per cycle and reports after N/CHUNK cycles.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               rst,
  logic_unit_pipe_if.slave  bus
);

  localparam int NCHUNK = N / CHUNK;
  localparam int ACCW   = $clog2(N + 1);
  localparam int CW     = $clog2(CHUNK + 1);
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state_q;
  logic [N-1:0]      out_q;
  logic [N-1:0]      shift_q;
  logic [N-1:0]      result_d;
  logic [ACCW-1:0]   acc_q;
  logic [ACCW-1:0]   acc_d;
  logic [CNTW-1:0]   cnt_q;
  logic [CW-1:0]     chunkOnes;
  logic              outValid_q;
  logic              zero_q;
  logic              parity_q;
  logic              busy_q;
  logic              inReady;
  logic              accept;

  popcount_chunk #(.CHUNK(CHUNK)) uChunk (
    .slice_i (shift_q[CHUNK-1:0]),
    .ones_o  (chunkOnes)
  );

  assign inReady = (state_q == ST_IDLE) && (!outValid_q || bus.out_ready);
  assign accept  = bus.in_valid && inReady;
  assign acc_d   = acc_q + ACCW'(chunkOnes);

  // Single-cycle logic result for the opcode currently on the bus.
  always_comb begin
    result_d = '0;
    case (bus.opcode)
      OP_AND:  result_d = bus.a & bus.b;
      OP_OR:   result_d = bus.a | bus.b;
      OP_XOR:  result_d = bus.a ^ bus.b;
      OP_NOR:  result_d = ~(bus.a | bus.b);
      OP_NAND: result_d = ~(bus.a & bus.b);
      OP_XNOR: result_d = ~(bus.a ^ bus.b);
      OP_ANDN: result_d = bus.a & ~bus.b;
      default: result_d = '0;
    endcase
  end

  // FSM, result register and POPCNT datapath; a retiring result frees the
  // output register in the same cycle a new operation is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_q      <= '0;
      outValid_q <= 1'b0;
      zero_q     <= 1'b0;
      parity_q   <= 1'b0;
      busy_q     <= 1'b0;
      acc_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bus.opcode == OP_POPCNT) begin
              state_q    <= ST_COUNT;
              busy_q     <= 1'b1;
              shift_q    <= bus.a;
              acc_q      <= '0;
              cnt_q      <= CNTW'(NCHUNK - 1);
              outValid_q <= 1'b0;
            end else begin
              out_q      <= result_d;
              zero_q     <= (result_d == '0);
              parity_q   <= ^result_d;
              outValid_q <= 1'b1;
            end
          end else if (bus.out_ready) begin
            outValid_q <= 1'b0;
          end
        end
        ST_COUNT: begin
          acc_q   <= acc_d;
          shift_q <= shift_q >> CHUNK;
          cnt_q   <= cnt_q - CNTW'(1);
          if (cnt_q == '0) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            out_q      <= N'(acc_d);
            zero_q     <= (acc_d == '0);
            parity_q   <= ^acc_d;
            outValid_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q && outValid_q;
  assign bus.parity    = parity_q && outValid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe (N=32, CHUNK=8) plus a randomized
// scoreboard run on a second instance (N=16, CHUNK=4).
module tb_logic_unit_pipe;
  import logic_unit_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic_unit_pipe_if #(.N(32)) bus ();
  logic_unit_pipe_if #(.N(16)) bus16 ();

  logic_unit_pipe #(.N(32), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic_unit_pipe #(.N(16), .CHUNK(4)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input opcode_t op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = v;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
  endtask

  // Reference for the 16-bit instance: bit-by-bit population count.
  function automatic logic [15:0] model16(input logic [15:0] a, input logic [15:0] b, input opcode_t op);
    int ones;
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_XNOR: return ~(a ^ b);
      OP_ANDN: return a & ~b;
      default: begin
        ones = 0;
        for (int i = 0; i < 16; i++) ones += int'(a[i]);
        return 16'(ones);
      end
    endcase
  endfunction

  // POPCNT on the 32-bit instance: four busy cycles, result on the fifth.
  task automatic runPop(input logic [31:0] a, input logic [31:0] exp);
    applyStimulus(1'b1, OP_POPCNT, a, 32'h0);
    step();
    applyStimulus(1'b0, OP_AND, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checkOutput("pop_busy", 32'(bus.busy), 1);
      checkOutput("pop_inready", 32'(bus.in_ready), 0);
      checkOutput("pop_outvalid_low", 32'(bus.out_valid), 0);
      step();
    end
    checkOutput("pop_outvalid", 32'(bus.out_valid), 1);
    checkOutput("pop_busy_done", 32'(bus.busy), 0);
    checkOutput("pop_out", bus.out, exp);
    checkOutput("pop_zero", 32'(bus.zero), (exp == 0) ? 1 : 0);
  endtask

  logic [31:0] exp2 [7];
  logic [15:0] q16 [$];
  logic [15:0] ra;
  logic [15:0] rb;
  opcode_t     rop;
  logic        acc16;
  logic        ret16;
  logic [15:0] expv;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, OP_AND, 32'h0, 32'h0);
    bus.out_ready   = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.opcode    = OP_AND;
    bus16.out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_outvalid", 32'(bus.out_valid), 0);
    checkOutput("rst_busy", 32'(bus.busy), 0);
    checkOutput("rst_inready", 32'(bus.in_ready), 1);
    checkOutput("rst_out", bus.out, 0);

    // Reset in the middle of a POPCNT aborts it.
    applyStimulus(1'b1, OP_POPCNT, 32'hFFFF_FFFF, 32'h0);
    step();
    applyStimulus(1'b0, OP_AND, 32'h0, 32'h0);
    step();
    checkOutput("midpop_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    step();
    step();
    checkOutput("abort_outvalid", 32'(bus.out_valid), 0);
    checkOutput("abort_busy", 32'(bus.busy), 0);
    checkOutput("abort_inready", 32'(bus.in_ready), 1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checkOutput("abort_noresult", 32'(bus.out_valid), 0);

    // Back-to-back logic ops, one result per cycle.
    exp2[0] = 32'hF000_F000; exp2[1] = 32'hFFF0_FFF0; exp2[2] = 32'h0FF0_0FF0;
    exp2[3] = 32'h000F_000F; exp2[4] = 32'h0FFF_0FFF; exp2[5] = 32'hF00F_F00F;
    exp2[6] = 32'h00F0_00F0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, opcode_t'(i), 32'hF0F0_F0F0, 32'hFF00_FF00);
      step();
      checkOutput("b2b_valid", 32'(bus.out_valid), 1);
      checkOutput("b2b_out", bus.out, exp2[i]);
      checkOutput("b2b_parity", 32'(bus.parity), 0);
    end
    applyStimulus(1'b0, OP_AND, 32'h0, 32'h0);
    step();
    checkOutput("b2b_drain", 32'(bus.out_valid), 0);

    // XOR of equal operands, then a parity-odd result.
    applyStimulus(1'b1, OP_XOR, 32'h1234_5678, 32'h1234_5678);
    step();
    checkOutput("xor_out", bus.out, 0);
    checkOutput("xor_zero", 32'(bus.zero), 1);
    checkOutput("xor_parity", 32'(bus.parity), 0);
    applyStimulus(1'b1, OP_AND, 32'h0000_0001, 32'h0000_0001);
    step();
    checkOutput("and_parity", 32'(bus.parity), 1);
    checkOutput("and_zero", 32'(bus.zero), 0);

    // POPCNT boundaries; the first accept also retires the prior result.
    runPop(32'hFFFF_FFFF, 32);
    runPop(32'h0000_0000, 0);
    runPop(32'h8000_0001, 2);
    step();

    // Backpressure: result held, new request ignored until out_ready.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, OP_OR, 32'h1, 32'h2);
    step();
    applyStimulus(1'b1, OP_AND, 32'hFF, 32'h0F);
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_out", bus.out, 3);
      checkOutput("bp_valid", 32'(bus.out_valid), 1);
      checkOutput("bp_inready", 32'(bus.in_ready), 0);
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(bus.in_ready), 1);
    step();
    checkOutput("bp_new_out", bus.out, 32'h0F);
    checkOutput("bp_new_valid", 32'(bus.out_valid), 1);
    applyStimulus(1'b0, OP_AND, 32'h0, 32'h0);
    step();
    checkOutput("bp_final_drop", 32'(bus.out_valid), 0);

    // Random ops and stalls on the 16-bit instance against the model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = opcode_t'($urandom_range(0, 7));
      bus16.in_valid  = ($urandom_range(0, 3) != 0);
      bus16.a         = ra;
      bus16.b         = rb;
      bus16.opcode    = rop;
      bus16.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc16 = bus16.in_valid && bus16.in_ready;
      ret16 = bus16.out_valid && bus16.out_ready;
      if (ret16) begin
        if (q16.size() == 0) begin
          checkOutput("rnd_unexpected", 32'(bus16.out), 32'hDEAD);
        end else begin
          expv = q16.pop_front();
          checkOutput("rnd_out", 32'(bus16.out), 32'(expv));
          checkOutput("rnd_zero", 32'(bus16.zero), (expv == 0) ? 1 : 0);
        end
      end
      if (acc16) q16.push_back(model16(ra, rb, rop));
      step();
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && q16.size() != 0; cyc++) begin
      #1;
      if (bus16.out_valid) begin
        expv = q16.pop_front();
        checkOutput("drain_out", 32'(bus16.out), 32'(expv));
      end
      step();
    end
    checkOutput("drain_empty", 32'(q16.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
